// File: rtl/vend_pkg.sv
// Shared types, coin encoding and price table helpers for the vending transaction path.
package vend_pkg;

  localparam int unsigned NUM_ITEMS = 5;
  localparam int unsigned CREDIT_W  = 8;
  localparam int unsigned CODE_W    = 2;
  localparam int unsigned SEL_W     = 3;

  localparam logic [CODE_W-1:0] COIN_1  = 2'd0;
  localparam logic [CODE_W-1:0] COIN_5  = 2'd1;
  localparam logic [CODE_W-1:0] COIN_10 = 2'd2;
  localparam logic [CODE_W-1:0] COIN_20 = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHANGE = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [NUM_ITEMS-1:0][CREDIT_W-1:0] price_arr_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [CODE_W-1:0] code);
    case (code)
      COIN_1:  coin_value = CREDIT_W'(1);
      COIN_5:  coin_value = CREDIT_W'(5);
      COIN_10: coin_value = CREDIT_W'(10);
      default: coin_value = CREDIT_W'(20);
    endcase
  endfunction

  function automatic price_arr_t make_prices(input int unsigned p0, input int unsigned p1,
                                             input int unsigned p2, input int unsigned p3,
                                             input int unsigned p4);
    price_arr_t p;
    p[0] = CREDIT_W'(p0);
    p[1] = CREDIT_W'(p1);
    p[2] = CREDIT_W'(p2);
    p[3] = CREDIT_W'(p3);
    p[4] = CREDIT_W'(p4);
    return p;
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy change selector: largest coin not exceeding the given credit.
module change_coin_select
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [CODE_W-1:0]   o_code
);

  always_comb begin
    o_code = COIN_1;
    if (i_credit >= coin_value(COIN_20))      o_code = COIN_20;
    else if (i_credit >= coin_value(COIN_10)) o_code = COIN_10;
    else if (i_credit >= coin_value(COIN_5))  o_code = COIN_5;
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit accumulation, purchase, refund/timeout payout
// over a valid/ready coin dispenser handshake.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = 7,
  parameter int unsigned PRICE1     = 5,
  parameter int unsigned PRICE2     = 6,
  parameter int unsigned PRICE3     = 10,
  parameter int unsigned PRICE4     = 8,
  parameter int unsigned CREDIT_MAX = 79,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_coin_valid,
  input  logic [CODE_W-1:0]    i_coin_code,
  input  logic                 i_buy_req,
  input  logic [SEL_W-1:0]     i_buy_sel,
  input  logic                 i_refund_req,
  input  logic                 i_disp_ready,
  output logic                 o_disp_valid,
  output logic [CODE_W-1:0]    o_disp_code,
  output logic                 o_coin_reject,
  output logic                 o_vend_valid,
  output logic [SEL_W-1:0]     o_vend_item,
  output logic                 o_buy_err,
  output logic                 o_refund_done,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic [NUM_ITEMS-1:0] o_affordable,
  output logic                 o_busy
);

  localparam price_arr_t PRICES = make_prices(PRICE0, PRICE1, PRICE2, PRICE3, PRICE4);
  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_LIMIT = CREDIT_W'(CREDIT_MAX);

  state_t               r_state;
  logic [CREDIT_W-1:0]  r_credit;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_disp_valid;
  logic                 r_coin_reject;
  logic                 r_vend_valid;
  logic [SEL_W-1:0]     r_vend_item;
  logic                 r_buy_err;
  logic                 r_refund_done;
  logic                 r_busy;

  logic [CODE_W-1:0]    w_disp_code;
  logic [CREDIT_W-1:0]  w_coin_sum;
  logic [CREDIT_W-1:0]  w_credit_after;
  logic                 w_sel_ok;
  logic [SEL_W-1:0]     w_sel_idx;
  logic [CREDIT_W-1:0]  w_price;
  logic                 w_any_event;
  logic                 w_timeout;
  logic                 w_start_refund;

  change_coin_select u_sel (
    .i_credit (r_credit),
    .o_code   (w_disp_code)
  );

  assign w_coin_sum     = r_credit + coin_value(i_coin_code);
  assign w_credit_after = r_credit - coin_value(w_disp_code);
  assign w_sel_ok       = (i_buy_sel < SEL_W'(NUM_ITEMS));
  assign w_sel_idx      = w_sel_ok ? i_buy_sel : '0;
  assign w_price        = PRICES[w_sel_idx];
  assign w_any_event    = i_refund_req || i_buy_req || i_coin_valid;
  assign w_timeout      = (r_credit != '0) && (r_to_cnt == TO_LAST);
  // Timeout only acts when no real event is pending this cycle
  assign w_start_refund = i_refund_req || (!w_any_event && w_timeout);

  always_comb begin
    o_affordable = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_affordable[i] = (r_credit >= PRICES[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_to_cnt      <= '0;
      r_disp_valid  <= 1'b0;
      r_coin_reject <= 1'b0;
      r_vend_valid  <= 1'b0;
      r_vend_item   <= '0;
      r_buy_err     <= 1'b0;
      r_refund_done <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      r_vend_valid  <= 1'b0;
      r_buy_err     <= 1'b0;
      r_refund_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_event || (r_credit == '0) || (r_to_cnt == TO_LAST)) r_to_cnt <= '0;
          else                                                         r_to_cnt <= r_to_cnt + TO_W'(1);

          if (w_start_refund) begin
            r_busy <= 1'b1;
            if (i_coin_valid) r_coin_reject <= 1'b1;
            if (r_credit != '0) begin
              r_state      <= CHANGE;
              r_disp_valid <= 1'b1;
            end else begin
              r_state       <= DONE;
              r_refund_done <= 1'b1;
            end
          end else if (i_buy_req) begin
            if (i_coin_valid) r_coin_reject <= 1'b1;
            if (!w_sel_ok || (r_credit < w_price)) begin
              r_buy_err <= 1'b1;
            end else begin
              r_credit     <= r_credit - w_price;
              r_vend_valid <= 1'b1;
              r_vend_item  <= i_buy_sel;
            end
          end else if (i_coin_valid) begin
            if (w_coin_sum <= CREDIT_LIMIT) r_credit      <= w_coin_sum;
            else                            r_coin_reject <= 1'b1;
          end
        end

        CHANGE: begin
          r_to_cnt <= '0;
          if (i_coin_valid) r_coin_reject <= 1'b1;
          if (r_disp_valid && i_disp_ready) begin
            r_credit <= w_credit_after;
            if (w_credit_after == '0) begin
              r_state       <= DONE;
              r_disp_valid  <= 1'b0;
              r_refund_done <= 1'b1;
            end
          end
        end

        DONE: begin
          r_to_cnt <= '0;
          if (i_coin_valid) r_coin_reject <= 1'b1;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_disp_valid <= 1'b0;
          r_to_cnt     <= '0;
        end
      endcase
    end
  end

  assign o_disp_valid  = r_disp_valid;
  assign o_disp_code   = w_disp_code;
  assign o_coin_reject = r_coin_reject;
  assign o_vend_valid  = r_vend_valid;
  assign o_vend_item   = r_vend_item;
  assign o_buy_err     = r_buy_err;
  assign o_refund_done = r_refund_done;
  assign o_credit      = r_credit;
  assign o_busy        = r_busy;

endmodule
